lsu_mem_stage: RTL and testbench
================================

Name: lsu_mem_stage

Overview:
- Load/store unit between the pipelined core's Memory stage and a handshaked data-memory bus; directly downstream of the EX/MEM pipeline register.
- Aligns store data and generates byte strobes; runs a req/ack transaction with timeout; stalls the pipeline while a transaction is outstanding.
- Returns sign/zero-extended load data to the MEM/WB register.
- Flags misaligned, illegal and timed-out accesses.

Parameters:
- TIMEOUT, 16: maximum cycles bus_req is held waiting for bus_ack before aborting (≥1).
- ADDR_WIDTH, 32: byte-address width of addr_m and bus_addr.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- mem_read_m  in  1  load in the M stage.
- mem_write_m  in  1  store in the M stage.
- funct3_m  in  3  RV32I size/sign code.
- addr_m  in  ADDR_WIDTH  byte address (ALUResultM).
- wdata_m  in  32  store data (WriteDataM).
- stall_m  out  1  freeze F/D/E/M pipeline registers.
- load_data_m  out  32  extended load result.
- access_err  out  1  one-cycle pulse: misaligned or illegal funct3.
- bus_err  out  1  one-cycle pulse: timeout abort.
- bus_req  out  1  transaction request, registered.
- bus_we  out  1  1 = write, registered.
- bus_addr  out  ADDR_WIDTH  word-aligned address, registered; bits [1:0] = 0.
- bus_wstrb  out  4  byte-lane enables, registered.
- bus_wdata  out  32  lane-replicated store data, registered.
- bus_rdata  in  32  read word, valid with bus_ack.
- bus_ack  in  1  completion; sampled only in BUSY.

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE; bus_req=0, bus_we=0, bus_addr=0, bus_wstrb=0, bus_wdata=0; load_data_m=0; access_err=0, bus_err=0; timeout counter=0.
- Reset mid-transaction drops bus_req on that edge. A late bus_ack is ignored.
- access = mem_read_m | mem_write_m. If both are set, the access is a store.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code is illegal.
- Misaligned: halfword with addr[0]=1, or word with addr[1:0]≠00.
- stall_m is combinational: 1 when (IDLE & access & legal & aligned) or BUSY; 0 otherwise.
- IDLE:
  - On access with legal/aligned operands: latch bus signals, addr offset and funct3; state→BUSY; bus_req=1 from the next cycle.
  - On access with illegal/misaligned operands: access_err=1 for the next cycle; no bus activity; stores are suppressed; load_data_m=0; no stall.
- BUSY:
  - bus_req held at 1 and all bus outputs held stable until bus_ack is sampled 1.
  - On ack: bus_req→0; for loads, capture the extended bus_rdata into load_data_m; state→DONE.
  - Counter increments each BUSY cycle without ack. If TIMEOUT cycles pass without ack: bus_req→0, bus_err pulse, load_data_m=0, state→DONE.
  - Ack in the same cycle the counter hits TIMEOUT counts as success.
- DONE:
  - stall_m=0 for exactly one cycle, so the pipeline advances and MEM/WB captures load_data_m. Inputs are ignored. state→IDLE.
  - Best-case latency: accept edge → 1 BUSY cycle with ack → DONE. Stall is 2 cycles; the result is valid in the DONE cycle.
- Stores:
  - SB: wstrb = 0001 << addr[1:0]; wdata = {4{wdata_m[7:0]}}.
  - SH: wstrb = 0011 << (2·addr[1]); wdata = {2{wdata_m[15:0]}}.
  - SW: wstrb = 1111; wdata = wdata_m.
  - Loads drive wstrb=0000, bus_we=0.
- Loads: byte selected by latched addr[1:0], halfword by addr[1]. LB/LH sign-extend; LBU/LHU zero-extend.
- load_data_m holds its value until the next load completion, error, or reset. Stores leave it unchanged.

Test Plan:
- LW addr=0x100, bus returns 0xDEADBEEF with ack 1 cycle after req → bus_addr=0x100, wstrb=0000, stall_m high 2 cycles, load_data_m=0xDEADBEEF in DONE.
- SB addr=0x203, wdata=0x000000A5 → bus_addr=0x200, wstrb=1000, bus_wdata=0xA5A5A5A5, bus_we=1; SH addr=0x202, wdata=0x1234 → wstrb=1100, bus_wdata=0x12341234.
- LB addr=0x301, rdata=0x00008000 → load_data_m=0xFFFFFF80; LBU same → 0x00000080; LH addr=0x302, rdata=0x80010000 → 0xFFFF8001.
- LW addr=0x102 → access_err pulses 1 cycle, bus_req never asserts, stall_m=0, load_data_m=0; funct3=011 load → access_err pulse.
- TIMEOUT=4, no ack → bus_req high exactly 4 cycles, bus_err pulse, load_data_m=0, stall releases the next cycle; repeat with ack in cycle 4 → success, no bus_err.
- Reset asserted in 2nd BUSY cycle → bus_req=0 after that edge; ack one cycle later is ignored; next LW completes normally.

Source files
------------

// File: rtl/lsu_mem_stage.sv
`timescale 1ns/1ps
// lsu_mem_stage: load/store unit sitting between the EX/MEM register and a
// req/ack data-memory bus. It aligns store data, generates byte strobes and
// runs one bus transaction per access, with a timeout. It also stalls the
// pipeline while the transaction is outstanding and returns the extended
// load data.
module lsu_mem_stage #(
  parameter int TIMEOUT    = 16,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_read_m,
  input  logic                  mem_write_m,
  input  logic [2:0]            funct3_m,
  input  logic [ADDR_WIDTH-1:0] addr_m,
  input  logic [31:0]           wdata_m,
  output logic                  stall_m,
  output logic [31:0]           load_data_m,
  output logic                  access_err,
  output logic                  bus_err,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [3:0]            bus_wstrb,
  output logic [31:0]           bus_wdata,
  input  logic [31:0]           bus_rdata,
  input  logic                  bus_ack
);

  // The counter only needs to reach TIMEOUT-1: the abort happens on the
  // edge that would have taken it to TIMEOUT.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  state_e                  state_q;
  logic [CW-1:0]           cnt_q;
  logic                    bus_req_q;
  logic                    bus_we_q;
  logic [ADDR_WIDTH-1:0]   bus_addr_q;
  logic [3:0]              bus_wstrb_q;
  logic [31:0]             bus_wdata_q;
  logic [31:0]             load_data_q;
  logic                    access_err_q;
  logic                    bus_err_q;
  logic [1:0]              off_q;   // byte offset of the pending load
  logic [2:0]              f3_q;    // size/sign code of the pending load

  logic        access;
  logic        legal;
  logic        aligned;
  logic        start_ok;
  logic        start_bad;
  logic [3:0]  wstrb_d;
  logic [31:0] wdata_d;
  logic [31:0] load_data_d;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Decode the incoming access: legality, alignment, strobes and lane data.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (otherwise synthesis infers a latch).
    access  = mem_read_m | mem_write_m;
    legal   = 1'b0;
    aligned = 1'b1;
    wstrb_d = 4'b0000;
    wdata_d = 32'h0;
    if (mem_write_m) begin
      // A store wins when both read and write are flagged.
      case (funct3_m)
        3'b000: begin
          legal   = 1'b1;
          wstrb_d = 4'b0001 << addr_m[1:0];
          wdata_d = {4{wdata_m[7:0]}};
        end
        3'b001: begin
          legal   = 1'b1;
          aligned = ~addr_m[0];
          wstrb_d = 4'b0011 << {addr_m[1], 1'b0};
          wdata_d = {2{wdata_m[15:0]}};
        end
        3'b010: begin
          legal   = 1'b1;
          aligned = (addr_m[1:0] == 2'b00);
          wstrb_d = 4'b1111;
          wdata_d = wdata_m;
        end
        default: legal = 1'b0;
      endcase
    end else begin
      case (funct3_m)
        3'b000, 3'b100: legal = 1'b1;
        3'b001, 3'b101: begin
          legal   = 1'b1;
          aligned = ~addr_m[0];
        end
        3'b010: begin
          legal   = 1'b1;
          aligned = (addr_m[1:0] == 2'b00);
        end
        default: legal = 1'b0;
      endcase
    end
    start_ok  = (state_q == S_IDLE) & access & legal & aligned;
    start_bad = (state_q == S_IDLE) & access & ~(legal & aligned);
  end

  // Select and extend the returned word using the latched offset and size.
  always_comb begin
    lane_b = bus_rdata[{off_q, 3'b000} +: 8];
    lane_h = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (f3_q[1:0])
      2'b00:   load_data_d = f3_q[2] ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
      2'b01:   load_data_d = f3_q[2] ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: load_data_d = bus_rdata;
    endcase
  end

  // Transaction FSM with registered bus outputs and error pulses.
  always_ff @(posedge clk) begin
    // NOTE: state is written with non-blocking assignments so every register
    // samples the values from before this edge, independent of statement order.
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_wstrb_q  <= 4'b0000;
      bus_wdata_q  <= 32'h0;
      load_data_q  <= 32'h0;
      access_err_q <= 1'b0;
      bus_err_q    <= 1'b0;
      off_q        <= 2'b00;
      f3_q         <= 3'b000;
    end else begin
      access_err_q <= 1'b0;
      bus_err_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_ok) begin
            state_q     <= S_BUSY;
            cnt_q       <= '0;
            bus_req_q   <= 1'b1;
            bus_we_q    <= mem_write_m;
            bus_addr_q  <= {addr_m[ADDR_WIDTH-1:2], 2'b00};
            bus_wstrb_q <= wstrb_d;
            bus_wdata_q <= wdata_d;
            off_q       <= addr_m[1:0];
            f3_q        <= funct3_m;
          end else if (start_bad) begin
            access_err_q <= 1'b1;
            load_data_q  <= 32'h0;
          end
        end
        S_BUSY: begin
          if (bus_ack) begin
            // An ack on the final allowed cycle still counts as success.
            bus_req_q <= 1'b0;
            state_q   <= S_DONE;
            if (!bus_we_q) load_data_q <= load_data_d;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            bus_req_q   <= 1'b0;
            bus_err_q   <= 1'b1;
            load_data_q <= 32'h0;
            state_q     <= S_DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Stall as soon as a good access is seen, and for the whole BUSY phase.
  assign stall_m     = start_ok | (state_q == S_BUSY);
  assign load_data_m = load_data_q;
  assign access_err  = access_err_q;
  assign bus_err     = bus_err_q;
  assign bus_req     = bus_req_q;
  assign bus_we      = bus_we_q;
  assign bus_addr    = bus_addr_q;
  assign bus_wstrb   = bus_wstrb_q;
  assign bus_wdata   = bus_wdata_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
`timescale 1ns/1ps
// Bench for lsu_mem_stage: transaction-level expectation model plus a
// per-cycle compare process, with literal pins from the directed vectors.
module tb_lsu_mem_stage;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read_m, mem_write_m;
  logic [2:0]  funct3_m;
  logic [31:0] addr_m, wdata_m;
  logic        stall_m;
  logic [31:0] load_data_m;
  logic        access_err, bus_err;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata, bus_rdata;
  logic        bus_ack;

  lsu_mem_stage #(.TIMEOUT(TMO), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read_m(mem_read_m), .mem_write_m(mem_write_m),
    .funct3_m(funct3_m), .addr_m(addr_m), .wdata_m(wdata_m),
    .stall_m(stall_m), .load_data_m(load_data_m),
    .access_err(access_err), .bus_err(bus_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Expected outputs for the current cycle.
  logic        exp_stall = 0, exp_req = 0, exp_we = 0, exp_aerr = 0, exp_berr = 0;
  logic [31:0] exp_addr = 0, exp_wdata = 0, exp_ld = 0;
  logic [3:0]  exp_wstrb = 0;

  // Observations gathered during one transaction.
  int          stall_cnt, req_cnt, aerr_cnt, berr_cnt;
  logic [31:0] obs_addr, obs_wdata;
  logic [3:0]  obs_wstrb;
  logic        obs_we;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("stall_m", 32'(stall_m), 32'(exp_stall));
      check("bus_req", 32'(bus_req), 32'(exp_req));
      check("load_data_m", load_data_m, exp_ld);
      check("access_err", 32'(access_err), 32'(exp_aerr));
      check("bus_err", 32'(bus_err), 32'(exp_berr));
      if (exp_req) begin
        check("bus_we", 32'(bus_we), 32'(exp_we));
        check("bus_addr", bus_addr, exp_addr);
        check("bus_wstrb", 32'(bus_wstrb), 32'(exp_wstrb));
        if (exp_we) check("bus_wdata", bus_wdata, exp_wdata);
      end
    end
  end

  task automatic sample_step();
    @(negedge clk);
    stall_cnt += int'(stall_m);
    req_cnt   += int'(bus_req);
    aerr_cnt  += int'(access_err);
    berr_cnt  += int'(bus_err);
    if (bus_req) begin
      obs_addr  = bus_addr;
      obs_wstrb = bus_wstrb;
      obs_wdata = bus_wdata;
      obs_we    = bus_we;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_read_m  = 1'b0;
    mem_write_m = 1'b0;
    funct3_m    = 3'b000;
    addr_m      = 32'h0;
    wdata_m     = 32'h0;
    bus_ack     = 1'b0;
  endtask

  // One pipeline access. ack_at = BUSY cycle (1-based) carrying bus_ack, 0 = never.
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input int ack_at, input logic [31:0] rdata);
    bit          ok, tmo;
    int          size, off;
    logic [3:0]  strb;
    logic [31:0] rep, ext;
    logic [7:0]  b;
    logic [15:0] h;
    stall_cnt = 0; req_cnt = 0; aerr_cnt = 0; berr_cnt = 0;
    obs_addr = 32'hx; obs_wstrb = 4'hx; obs_wdata = 32'hx; obs_we = 1'bx;

    size = 1 << f3[1:0];
    off  = int'(addr % 4);
    if (wr) ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
    else    ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    ok = ok && ((off % size) == 0);
    for (int i = 0; i < 4; i++) begin
      strb[i]        = wr && ok && (i >= off) && (i < off + size);
      rep[8*i +: 8]  = wd[8*(i % (size > 4 ? 4 : size)) +: 8];
    end
    b = 8'(rdata >> (8 * off));
    h = 16'(rdata >> (16 * (off / 2)));
    case (f3)
      3'd0:    ext = 32'($signed(b));
      3'd4:    ext = {24'h0, b};
      3'd1:    ext = 32'($signed(h));
      3'd5:    ext = {16'h0, h};
      default: ext = rdata;
    endcase

    mem_read_m = rd; mem_write_m = wr; funct3_m = f3; addr_m = addr; wdata_m = wd;
    bus_ack = 1'b0; bus_rdata = rdata;
    exp_req = 0; exp_aerr = 0; exp_berr = 0; exp_stall = ok;
    sample_step();

    if (!ok) begin
      idle_inputs();
      exp_aerr = 1; exp_ld = 32'h0; exp_stall = 0;
      sample_step();
      exp_aerr = 0;
      return;
    end

    exp_req = 1; exp_we = wr; exp_addr = addr & ~32'h3; exp_wstrb = strb; exp_wdata = rep;
    tmo = 1'b1;
    for (int n = 1; n <= TMO; n++) begin
      bus_ack = (n == ack_at);
      sample_step();
      if (n == ack_at) begin
        tmo = 1'b0;
        break;
      end
    end
    // DONE: inputs are still presented but must be ignored.
    bus_ack = 1'b0; exp_req = 0; exp_stall = 0; exp_berr = tmo;
    if (tmo)      exp_ld = 32'h0;
    else if (!wr) exp_ld = ext;
    sample_step();
    idle_inputs();
    exp_berr = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    bus_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;
    check("rst_bus_addr", bus_addr, 32'h0);
    check("rst_bus_wstrb", 32'(bus_wstrb), 32'h0);
    check("rst_bus_wdata", bus_wdata, 32'h0);
    check("rst_bus_we", 32'(bus_we), 32'h0);
    sample_step();

    // LW 0x100, ack in first BUSY cycle.
    run_access(1, 0, 3'b010, 32'h100, 32'h0, 1, 32'hDEADBEEF);
    check("lw_addr", obs_addr, 32'h100);
    check("lw_wstrb", 32'(obs_wstrb), 32'h0);
    check("lw_stall_cycles", stall_cnt, 2);
    check("lw_data", load_data_m, 32'hDEADBEEF);

    // SB 0x203 and SH 0x202.
    run_access(0, 1, 3'b000, 32'h203, 32'h000000A5, 1, 32'h0);
    check("sb_addr", obs_addr, 32'h200);
    check("sb_wstrb", 32'(obs_wstrb), 32'b1000);
    check("sb_wdata", obs_wdata, 32'hA5A5A5A5);
    check("sb_we", 32'(obs_we), 32'h1);
    check("sb_keeps_load", load_data_m, 32'hDEADBEEF);
    run_access(0, 1, 3'b001, 32'h202, 32'h00001234, 2, 32'h0);
    check("sh_wstrb", 32'(obs_wstrb), 32'b1100);
    check("sh_wdata", obs_wdata, 32'h12341234);

    // Sign and zero extension.
    run_access(1, 0, 3'b000, 32'h301, 32'h0, 2, 32'h00008000);
    check("lb_data", load_data_m, 32'hFFFFFF80);
    run_access(1, 0, 3'b100, 32'h301, 32'h0, 1, 32'h00008000);
    check("lbu_data", load_data_m, 32'h00000080);
    run_access(1, 0, 3'b001, 32'h302, 32'h0, 3, 32'h80010000);
    check("lh_data", load_data_m, 32'hFFFF8001);
    run_access(1, 0, 3'b101, 32'h300, 32'h0, 1, 32'h1234F00D);
    check("lhu_data", load_data_m, 32'h0000F00D);

    // Misaligned and illegal accesses.
    run_access(1, 0, 3'b010, 32'h102, 32'h0, 1, 32'h0);
    check("mis_req_cycles", req_cnt, 0);
    check("mis_stall_cycles", stall_cnt, 0);
    check("mis_err_pulses", aerr_cnt, 1);
    check("mis_data", load_data_m, 32'h0);
    run_access(1, 0, 3'b011, 32'h100, 32'h0, 1, 32'h0);
    check("ill_ld_err_pulses", aerr_cnt, 1);
    run_access(0, 1, 3'b001, 32'h201, 32'h5555, 1, 32'h0);
    check("mis_sh_req_cycles", req_cnt, 0);
    run_access(0, 1, 3'b100, 32'h200, 32'h5555, 1, 32'h0);
    check("ill_st_err_pulses", aerr_cnt, 1);

    // Read and write both set: store wins.
    run_access(1, 1, 3'b010, 32'h10C, 32'hCAFEF00D, 1, 32'h11111111);
    check("rw_is_store", 32'(obs_we), 32'h1);
    check("sw_wstrb", 32'(obs_wstrb), 32'hF);

    // Timeout with no ack, then ack on the last allowed cycle.
    run_access(1, 0, 3'b010, 32'h104, 32'h0, 1, 32'h76543210);
    run_access(1, 0, 3'b010, 32'h108, 32'h0, 0, 32'h0);
    check("tmo_req_cycles", req_cnt, TMO);
    check("tmo_err_pulses", berr_cnt, 1);
    check("tmo_stall_cycles", stall_cnt, TMO + 1);
    check("tmo_data", load_data_m, 32'h0);
    run_access(1, 0, 3'b010, 32'h108, 32'h0, TMO, 32'h0BADF00D);
    check("late_ack_err", berr_cnt, 0);
    check("late_ack_data", load_data_m, 32'h0BADF00D);

    // Reset during the second BUSY cycle; the following ack is ignored.
    mem_read_m = 1; funct3_m = 3'b010; addr_m = 32'h400; bus_rdata = 32'h99999999;
    exp_stall = 1; exp_req = 0;
    sample_step();
    exp_req = 1; exp_we = 0; exp_addr = 32'h400; exp_wstrb = 4'h0;
    sample_step();
    rst_n = 1'b0;
    sample_step();
    rst_n = 1'b1;
    idle_inputs();
    bus_ack = 1'b1;
    exp_req = 0; exp_stall = 0; exp_ld = 32'h0;
    sample_step();
    bus_ack = 1'b0;
    sample_step();
    check("rst_mid_data", load_data_m, 32'h0);
    run_access(1, 0, 3'b010, 32'h400, 32'h0, 1, 32'h13572468);
    check("post_rst_lw", load_data_m, 32'h13572468);

    sample_step();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
